// File: rtl/eci_cmd_defs.sv
// rtl/eci_cmd_defs.sv - ECI command field widths shared across the DCS blocks.
package eci_cmd_defs;

  localparam int ECI_WORD_WIDTH        = 64;
  localparam int ECI_PACKET_SIZE_WIDTH = 5;

endpackage

// File: rtl/eci_dcs_defs.sv
// rtl/eci_dcs_defs.sv - DCS types built on the ECI command widths.
package eci_dcs_defs;

  import eci_cmd_defs::*;

  // One header beat as it travels through the response arbiter slot.
  typedef struct packed {
    logic [ECI_WORD_WIDTH-1:0]        hdr;
    logic [ECI_PACKET_SIZE_WIDTH-1:0] size;
    logic [3:0]                       vc;
  } eci_hdr_beat_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - circular first-one search starting at ptr; one-hot grant.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcs_rsp_arb.sv
// rtl/dcs_rsp_arb.sv - round-robin merge of ECI header channels into one registered slot.
module dcs_rsp_arb
  import eci_cmd_defs::*;
  import eci_dcs_defs::*;
#(
  parameter int NUM_IN    = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_IN*ECI_WORD_WIDTH-1:0]        in_hdr_i,
  input  logic [NUM_IN*ECI_PACKET_SIZE_WIDTH-1:0] in_pkt_size_i,
  input  logic [NUM_IN*4-1:0]                     in_pkt_vc_i,
  input  logic [NUM_IN-1:0]                       in_pkt_valid_i,
  output logic [NUM_IN-1:0]                       in_pkt_ready_o,
  output logic [ECI_WORD_WIDTH-1:0]               out_hdr_o,
  output logic [ECI_PACKET_SIZE_WIDTH-1:0]        out_pkt_size_o,
  output logic [3:0]                              out_pkt_vc_o,
  output logic                                    out_pkt_valid_o,
  input  logic                                    out_pkt_ready_i,
  input  logic                                    cnt_clear_i,
  output logic [NUM_IN*CNT_WIDTH-1:0]             grant_cnt_o
);

  localparam int             PW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [PW-1:0]  LAST = PW'(NUM_IN - 1);

  eci_hdr_beat_t         slot_q;
  eci_hdr_beat_t         sel_beat;
  logic                  slot_vld_q;
  logic                  running_q;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gidx;
  logic [NUM_IN-1:0]     gnt;
  logic                  any;
  logic                  loadable;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_IN];

  rr_pick #(
    .N  (NUM_IN),
    .PW (PW)
  ) u_pick (
    .req (in_pkt_valid_i),
    .ptr (rr_ptr),
    .gnt (gnt),
    .any (any)
  );

  // running_q holds off acceptance for the first edge after reset releases.
  assign loadable       = !slot_vld_q || out_pkt_ready_i;
  assign accept         = any && loadable && running_q;
  assign in_pkt_ready_o = gnt & {NUM_IN{loadable && running_q}};

  always_comb begin
    sel_beat = '0;
    gidx     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        sel_beat.hdr  = in_hdr_i[i*ECI_WORD_WIDTH +: ECI_WORD_WIDTH];
        sel_beat.size = in_pkt_size_i[i*ECI_PACKET_SIZE_WIDTH +: ECI_PACKET_SIZE_WIDTH];
        sel_beat.vc   = in_pkt_vc_i[i*4 +: 4];
        gidx          = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      running_q  <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      running_q <= 1'b1;
      if (accept) begin
        slot_q     <= sel_beat;
        slot_vld_q <= 1'b1;
        rr_ptr     <= (gidx == LAST) ? '0 : gidx + PW'(1);
      end else if (out_pkt_ready_i) begin
        slot_vld_q <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else if (cnt_clear_i) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (accept && gnt[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign out_hdr_o       = slot_q.hdr;
  assign out_pkt_size_o  = slot_q.size;
  assign out_pkt_vc_o    = slot_q.vc;
  assign out_pkt_valid_o = slot_vld_q;

endmodule
